seg7_scan_decode: RTL and testbench
===================================

SEG7_SCAN_DECODE -- requirements
Module: seg7_scan_decode

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed display digits.
REQ-002 Parameter STABLE_CYC, default 3 (range 1..15): consecutive identical samples required before a digit is accepted.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 an  input  DIGITS  digit select, active-low; one zero bit selects digit index i.
REQ-006 seg  input  7  segment bus, active-low; bit0 = segment a through bit6 = segment g.
REQ-007 value  output  4*DIGITS  last complete frame; digit i occupies value[4i+3:4i].
REQ-008 valid  output  1  one-cycle pulse marking a new value.
REQ-009 frame_err  output  1  at least one digit of the frame in value carried an undecodable pattern.
REQ-010 busy  output  1  high while at least one digit of the current frame is captured.

Function
REQ-011 Decoding SHALL be the exact inverse of the team's hex-to-7-segment table: 7'b1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F.
REQ-012 A sample is qualified when an has exactly one zero bit; all-ones or multi-zero an is unqualified.
REQ-013 Registered previous sample {an,seg}; stability counter stab, width enough for STABLE_CYC.
REQ-014 Unqualified sample: stab <= 0, no capture.
REQ-015 Qualified sample differing from previous sample (or previous unqualified): stab <= 1.
REQ-016 Qualified sample equal to previous: stab increments, saturating at STABLE_CYC.
REQ-017 Capture SHALL occur on the edge at which stab becomes STABLE_CYC (exactly once per dwell); STABLE_CYC=1 captures on the first qualified sample.
REQ-018 Capture of a decodable pattern writes nibble into shadow slot i, clears slot error bit, sets mask[i].
REQ-019 Capture of an undecodable pattern writes 4'h0 into slot i, sets slot error bit, sets mask[i].
REQ-020 Re-capture of an already-captured digit within the same frame overwrites slot and its error bit.
REQ-021 FSM states: SCAN, DONE. SCAN -> DONE on the edge after mask becomes all ones; DONE -> SCAN unconditionally next edge.
REQ-022 On SCAN->DONE edge: value <= shadow, frame_err <= OR of slot error bits, valid <= 1, mask <= 0.
REQ-023 valid SHALL be high exactly one cycle (during DONE); latency: valid high in the cycle after the final-digit capture edge.
REQ-024 During DONE, stab and previous sample SHALL hold; no capture occurs; counting resumes in SCAN.
REQ-025 value and frame_err SHALL hold between frames.
REQ-026 busy SHALL equal (mask != 0) registered with mask.

Reset
REQ-027 On rst assertion, asynchronously: value=0, valid=0, frame_err=0, busy=0, mask=0, shadow=0, slot errors=0, stab=0, previous sample={all-ones,7'b1111111}, state=SCAN.
REQ-028 Reset mid-frame SHALL discard all partial captures; the first frame after release requires all DIGITS digits again.

Verification (DIGITS=8, STABLE_CYC=3)
REQ-029 Digits 0..7 each driven 5 cycles with patterns for 32'h1234ABCD (digit 0 = D) -> exactly one valid pulse, value=32'h1234ABCD, frame_err=0, valid one cycle after digit 7 capture.
REQ-030 Digit 2 shows 0x4 for 2 cycles then 0x9 for 3 cycles -> slot 2 = 9; no capture of 4.
REQ-031 Digit 5 driven seg=7'b1111111 for 4 cycles, others valid -> value[23:20]=0, frame_err=1; next clean frame -> frame_err=0.
REQ-032 an=8'hFF for 20 cycles, then an=8'hFC for 20 cycles -> no capture, busy=0, valid never asserted.
REQ-033 rst pulsed after digits 0..3 captured -> all outputs 0 immediately; subsequent 4 digits alone produce no valid.
REQ-034 Same digit held 50 cycles -> single capture; valid only after all other digits captured.

Source files
------------

// File: rtl/seg7_scan_decode.sv
// Recovers hex digits from a multiplexed, active-low 7-segment scan bus.
// A digit is accepted after STABLE_CYC identical qualified samples; a full frame is published with a one-cycle valid pulse.
module seg7_scan_decode #(
    parameter int DIGITS     = 8,
    parameter int STABLE_CYC = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            seg,
    output logic [4*DIGITS-1:0]   value,
    output logic                  valid,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int            SW       = $clog2(STABLE_CYC + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC);

    typedef enum logic {SCAN, DONE} state_t;

    state_t                r_state;
    logic [DIGITS-1:0]     r_prev_an;
    logic [6:0]            r_prev_seg;
    logic [SW-1:0]         r_stab;
    logic [DIGITS-1:0]     r_mask;
    logic [4*DIGITS-1:0]   r_shadow;
    logic [DIGITS-1:0]     r_slot_err;
    logic [4*DIGITS-1:0]   r_value;
    logic                  r_valid;
    logic                  r_frame_err;
    logic                  r_busy;

    logic                  w_qual;
    logic                  w_same;
    logic                  w_capture;
    logic                  w_dec_ok;
    logic [3:0]            w_nib;
    logic [SW-1:0]         w_stab_next;
    logic [DIGITS-1:0]     w_slot_we;
    logic [DIGITS-1:0]     w_mask_next;

    assign w_qual = $onehot(~an);
    assign w_same = (an == r_prev_an) && (seg == r_prev_seg);

    always_comb begin
        w_stab_next = r_stab;
        if (!w_qual)
            w_stab_next = '0;
        else if (!w_same)
            w_stab_next = SW'(1);
        else if (r_stab != STAB_MAX)
            w_stab_next = r_stab + SW'(1);
    end

    // A fresh dwell can reach the threshold immediately when STABLE_CYC is 1.
    assign w_capture = (r_state == SCAN) && w_qual && (w_stab_next == STAB_MAX)
                       && (!w_same || (r_stab != STAB_MAX));

    always_comb begin
        w_nib    = 4'h0;
        w_dec_ok = 1'b1;
        case (seg)
            7'b1000000: w_nib = 4'h0;
            7'b1111001: w_nib = 4'h1;
            7'b0100100: w_nib = 4'h2;
            7'b0110000: w_nib = 4'h3;
            7'b0011001: w_nib = 4'h4;
            7'b0010010: w_nib = 4'h5;
            7'b0000010: w_nib = 4'h6;
            7'b1111000: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0010000: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b0000011: w_nib = 4'hB;
            7'b1000110: w_nib = 4'hC;
            7'b0100001: w_nib = 4'hD;
            7'b0000110: w_nib = 4'hE;
            7'b0001110: w_nib = 4'hF;
            default:    w_dec_ok = 1'b0;
        endcase
    end

    // Qualified an has a single zero, so it doubles as the slot write-enable vector.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slot
            assign w_slot_we[gi] = w_capture & ~an[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_shadow[4*gi +: 4] <= 4'h0;
                    r_slot_err[gi]      <= 1'b0;
                end else if (w_slot_we[gi]) begin
                    r_shadow[4*gi +: 4] <= w_nib;
                    r_slot_err[gi]      <= ~w_dec_ok;
                end
            end
        end
    endgenerate

    assign w_mask_next = r_mask | w_slot_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SCAN;
            r_prev_an   <= '1;
            r_prev_seg  <= '1;
            r_stab      <= '0;
            r_mask      <= '0;
            r_value     <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else if (r_state == SCAN) begin
            r_prev_an  <= an;
            r_prev_seg <= seg;
            r_stab     <= w_stab_next;
            if (&r_mask) begin
                r_state     <= DONE;
                r_value     <= r_shadow;
                r_frame_err <= |r_slot_err;
                r_valid     <= 1'b1;
                r_mask      <= '0;
                r_busy      <= 1'b0;
            end else begin
                r_mask  <= w_mask_next;
                r_busy  <= |w_mask_next;
                r_valid <= 1'b0;
            end
        end else begin
            r_state <= SCAN;
            r_valid <= 1'b0;
        end
    end

    assign value     = r_value;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;
endmodule

// File: tb/tb_seg7_scan_decode.sv
// Bench for seg7_scan_decode: directed frames, reset and idle cases, then random dwells,
// all checked cycle by cycle against a run-length reference model.
module tb_seg7_scan_decode;
    localparam int DIGITS = 8;
    localparam int STABLE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [31:0] value;
    logic        valid;
    logic        frame_err;
    logic        busy;

    seg7_scan_decode #(.DIGITS(DIGITS), .STABLE_CYC(STABLE)) dut (
        .clk(clk), .rst(rst), .an(an), .seg(seg),
        .value(value), .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [6:0] segtab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model state: length of the current run of identical samples, not a saturating counter.
    logic [7:0]  m_prev_an;
    logic [6:0]  m_prev_seg;
    int          m_run;
    bit          m_done;
    logic [7:0]  m_mask;
    logic [3:0]  m_shadow [8];
    bit          m_err [8];
    logic [31:0] m_value;
    logic        m_ferr, m_valid, m_busy;

    int n_cmp = 0, n_fail = 0, cyc_cnt = 0, valid_cnt = 0, valid_cyc = 0;

    function automatic bit decode(input logic [6:0] s, output logic [3:0] nib);
        nib = 4'h0;
        for (int k = 0; k < 16; k++)
            if (segtab[k] === s) begin nib = 4'(k); return 1'b1; end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_prev_an = 8'hFF; m_prev_seg = 7'h7F; m_run = 0; m_done = 0; m_mask = 8'h00;
        for (int k = 0; k < 8; k++) begin m_shadow[k] = 4'h0; m_err[k] = 0; end
        m_value = 32'h0; m_ferr = 0; m_valid = 0; m_busy = 0;
    endtask

    task automatic model_edge(input logic [7:0] a, input logic [6:0] s);
        bit qual, cap, ok;
        int slot;
        logic [3:0] nib;
        if (m_done) begin m_done = 0; m_valid = 0; return; end
        qual = ($countones(~a) == 1);
        if (!qual) m_run = 0;
        else if (a !== m_prev_an || s !== m_prev_seg) m_run = 1;
        else m_run++;
        m_prev_an = a; m_prev_seg = s;
        cap  = qual && (m_run == STABLE);
        slot = 0;
        for (int k = 0; k < 8; k++) if (a[k] == 1'b0) slot = k;
        m_valid = 0;
        if (m_mask == 8'hFF) begin
            for (int k = 0; k < 8; k++) m_value[4*k +: 4] = m_shadow[k];
            m_ferr = 0;
            for (int k = 0; k < 8; k++) if (m_err[k]) m_ferr = 1;
            m_valid = 1; m_done = 1; m_mask = 8'h00;
        end else if (cap) begin
            m_mask[slot] = 1'b1;
        end
        if (cap) begin
            ok = decode(s, nib);
            m_shadow[slot] = nib;
            m_err[slot] = !ok;
        end
        m_busy = (m_mask != 0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc_cnt);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
        chk({tag, ".value"}, value, m_value);
    endtask

    task automatic cyc(input logic [7:0] a, input logic [6:0] s);
        an = a; seg = s;
        @(posedge clk);
        model_edge(a, s);
        #1;
        cyc_cnt++;
        if (valid === 1'b1) begin
            valid_cnt++; valid_cyc = cyc_cnt;
            $display("frame at cycle %0d: value=%h frame_err=%b", cyc_cnt, value, frame_err);
        end
        chk_outputs("cyc");
    endtask

    task automatic drive_raw(input int d, input logic [6:0] s, input int n);
        logic [7:0] a;
        a = 8'hFF; a[d] = 1'b0;
        for (int i = 0; i < n; i++) cyc(a, s);
    endtask

    task automatic drive_digit(input int d, input logic [3:0] nib, input int n);
        drive_raw(d, segtab[nib], n);
    endtask

    task automatic drive_frame(input logic [31:0] w, input int n);
        for (int d = 0; d < 8; d++) drive_digit(d, w[4*d +: 4], n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int v0, k, d1, d2, dw;
        logic [7:0]  a;
        logic [6:0]  s;
        logic [31:0] w;

        an = 8'hFF; seg = 7'h7F;
        do_reset();

        // Clean frame: one pulse, correct value, valid one cycle after digit 7 capture.
        w = 32'h1234ABCD;
        v0 = valid_cnt;
        for (int d = 0; d < 7; d++) drive_digit(d, w[4*d +: 4], 5);
        k = cyc_cnt;
        drive_digit(7, w[31:28], 5);
        chk("t1_latency", 32'(valid_cyc - (k + 3)), 32'd1);
        chk("t1_pulses", 32'(valid_cnt - v0), 32'd1);
        chk("t1_value", value, 32'h1234ABCD);
        chk("t1_ferr", 32'(frame_err), 32'd0);

        // Short dwell on digit 2 must not be captured.
        v0 = valid_cnt;
        drive_digit(0, 4'hD, 5); drive_digit(1, 4'hC, 5);
        drive_digit(2, 4'h4, 2); drive_digit(2, 4'h9, 3);
        for (int d = 3; d < 8; d++) drive_digit(d, w[4*d +: 4], 5);
        chk("t2_pulses", 32'(valid_cnt - v0), 32'd1);
        chk("t2_value", value, 32'h1234A9CD);

        // Blank digit 5 decodes as 0 with an error, then a clean frame clears it.
        for (int d = 0; d < 8; d++)
            if (d == 5) drive_raw(5, 7'b1111111, 4);
            else drive_digit(d, w[4*d +: 4], 4);
        chk("t3_value", value, 32'h1204ABCD);
        chk("t3_ferr", 32'(frame_err), 32'd1);
        drive_frame(w, 5);
        chk("t3_clean_ferr", 32'(frame_err), 32'd0);
        chk("t3_clean_value", value, 32'h1234ABCD);

        // No digit selected, then two digits selected: never qualified.
        v0 = valid_cnt;
        for (int i = 0; i < 20; i++) cyc(8'hFF, segtab[1]);
        for (int i = 0; i < 20; i++) cyc(8'hFC, segtab[2]);
        chk("t4_pulses", 32'(valid_cnt - v0), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);

        // Reset mid-frame discards partial captures.
        w = 32'h76543210;
        for (int d = 0; d < 4; d++) drive_digit(d, w[4*d +: 4], 5);
        chk("t5_busy_before", 32'(busy), 32'd1);
        do_reset();
        chk("t5_value", value, 32'h0);
        chk("t5_busy", 32'(busy), 32'd0);
        v0 = valid_cnt;
        for (int d = 4; d < 8; d++) drive_digit(d, w[4*d +: 4], 5);
        chk("t5_pulses", 32'(valid_cnt - v0), 32'd0);
        chk("t5_busy_after", 32'(busy), 32'd1);

        // Long dwell captures once; frame completes only after the other digits.
        do_reset();
        v0 = valid_cnt;
        drive_digit(0, w[3:0], 50);
        chk("t6_pulses_hold", 32'(valid_cnt - v0), 32'd0);
        chk("t6_busy_hold", 32'(busy), 32'd1);
        for (int d = 1; d < 8; d++) drive_digit(d, w[4*d +: 4], 5);
        chk("t6_pulses", 32'(valid_cnt - v0), 32'd1);
        chk("t6_value", value, 32'h76543210);

        // Random dwells, including glitches, unqualified selects and occasional resets.
        for (int t = 0; t < 400; t++) begin
            d1 = $urandom_range(0, 7);
            dw = $urandom_range(1, 6);
            a  = 8'hFF; a[d1] = 1'b0;
            s  = ($urandom_range(0, 99) < 85) ? segtab[$urandom_range(0, 15)] : 7'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                d2 = (d1 + 1 + $urandom_range(0, 6)) % 8;
                a[d2] = 1'b0;
                if ($urandom_range(0, 1) == 0) a = 8'hFF;
            end
            for (int i = 0; i < dw; i++) cyc(a, s);
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
